// File: rtl/rect_layer_compositor_pkg.sv
// Shared types for the rectangle compositor: rect_t slot descriptor, default widths, commit FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rect_pkg;

    localparam int RECT_XW = 9;
    localparam int RECT_YW = 8;

    typedef struct packed {
        logic               en;
        logic [RECT_XW-1:0] x0;
        logic [RECT_XW-1:0] x1;
        logic [RECT_YW-1:0] y0;
        logic [RECT_YW-1:0] y1;
    } rect_t;

    localparam rect_t RECT_NONE = '0;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } commit_state_t;

endpackage

// File: rtl/rect_layer_compositor_hit.sv
// Single-slot coverage test: enabled slot with inclusive, unsigned bounds on both axes.
// Latency: combinational.
// Backpressure: none; an inverted range (x0 > x1 or y0 > y1) simply never hits.
module rect_hit
    import rect_pkg::*;
(
    input  rect_t              rect,
    input  logic [RECT_XW-1:0] x,
    input  logic [RECT_YW-1:0] y,
    output logic               hit
);

    assign hit = rect.en
              && (x >= rect.x0) && (x <= rect.x1)
              && (y >= rect.y0) && (y <= rect.y1);

endmodule

// File: rtl/rect_layer_compositor.sv
// N-slot rectangle hit tester with shadow/active tables swapped only at frame_start (optional RECT_COLLIDE_EN).
// Latency: 2 cycles pixel -> hit outputs, one pixel per cycle, never stalls.
// Backpressure: cfg_ready drops while a commit is pending; writes resume once frame_start applies it.
module rect_layer_compositor
    import rect_pkg::*;
#(
    parameter int N_RECT = 8,
    parameter int XW     = RECT_XW,   // must match the package rect_t field widths
    parameter int YW     = RECT_YW,
    parameter int IDW    = $clog2(N_RECT)
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              pix_valid,
    input  logic [XW-1:0]     x,
    input  logic [YW-1:0]     y,
    input  logic              frame_start,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [IDW-1:0]    cfg_idx,
    input  rect_t             cfg_rect,
    input  logic              cfg_commit,
    output logic              hit_valid,
    output logic              hit,
    output logic [IDW-1:0]    hit_id,
    output logic [N_RECT-1:0] hit_mask,
    output logic              collide
);

    rect_t         shadow [N_RECT];
    rect_t         active [N_RECT];
    commit_state_t state, state_nxt;
    logic          apply_commit;
    logic          cfg_fire;

    logic [N_RECT-1:0] mask_comb;
    logic [N_RECT-1:0] mask_s1;
    logic              vld_s1;
    logic [IDW-1:0]    id_comb;

    assign cfg_ready    = (state == ST_IDLE);
    assign cfg_fire     = cfg_valid && cfg_ready;
    assign apply_commit = (state == ST_PENDING) && frame_start;

    // Commit FSM state register
    always_ff @(posedge clk) begin
        if (!nRst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Commit FSM next state: a commit seen in the frame_start cycle waits for the next frame
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (cfg_commit) state_nxt = ST_PENDING;
            ST_PENDING: if (frame_start && !cfg_commit) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Shadow writes (out-of-range index matches no slot and is dropped) and shadow->active swap
    always_ff @(posedge clk) begin
        if (!nRst) begin
            for (int i = 0; i < N_RECT; i++) begin
                shadow[i] <= RECT_NONE;
                active[i] <= RECT_NONE;
            end
        end else begin
            for (int i = 0; i < N_RECT; i++) begin
                if (cfg_fire && (cfg_idx == IDW'(i))) shadow[i] <= cfg_rect;
                if (apply_commit)                     active[i] <= shadow[i];
            end
        end
    end

    // One comparator per active slot
    for (genvar g = 0; g < N_RECT; g++) begin : g_slot
        rect_hit u_hit (
            .rect (active[g]),
            .x    (x),
            .y    (y),
            .hit  (mask_comb[g])
        );
    end

    // Stage 1: register coverage mask; zero when no pixel so stage 2 outputs stay clean
    always_ff @(posedge clk) begin
        if (!nRst) begin
            vld_s1  <= 1'b0;
            mask_s1 <= '0;
        end else begin
            vld_s1  <= pix_valid;
            mask_s1 <= pix_valid ? mask_comb : '0;
        end
    end

    // Lowest set bit of the stage-1 mask
    always_comb begin
        id_comb = '0;
        for (int i = N_RECT - 1; i >= 0; i--) begin
            if (mask_s1[i]) id_comb = IDW'(i);
        end
    end

    // Stage 2: reduce to hit / hit_id and present the mask
    always_ff @(posedge clk) begin
        if (!nRst) begin
            hit_valid <= 1'b0;
            hit       <= 1'b0;
            hit_id    <= '0;
            hit_mask  <= '0;
        end else begin
            hit_valid <= vld_s1;
            hit       <= |mask_s1;
            hit_id    <= id_comb;
            hit_mask  <= mask_s1;
        end
    end

`ifdef RECT_COLLIDE_EN
    logic collide_acc;
    logic multi_hit;

    assign multi_hit = hit_valid && ((hit_mask & (hit_mask - 1'b1)) != '0);

    // Per-frame overlap accumulator, published and restarted at frame_start
    always_ff @(posedge clk) begin
        if (!nRst) begin
            collide_acc <= 1'b0;
            collide     <= 1'b0;
        end else if (frame_start) begin
            collide     <= collide_acc;
            collide_acc <= multi_hit;
        end else begin
            collide_acc <= collide_acc | multi_hit;
        end
    end
`else
    assign collide = 1'b0;
`endif

endmodule

// File: tb/tb_rect_layer_compositor.sv
// Directed bench for rect_layer_compositor with six slots so an out-of-range index is expressible.
// Latency: checks hit outputs exactly 2 cycles after each pixel.
// Backpressure: exercises cfg_ready stall across pending commits.
module tb_rect_layer_compositor;
    import rect_pkg::*;

    localparam int N   = 6;
    localparam int IDW = $clog2(N);

    logic           clk = 1'b0;
    logic           nRst;
    logic           pix_valid;
    logic [8:0]     x;
    logic [7:0]     y;
    logic           frame_start;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [IDW-1:0] cfg_idx;
    rect_t          cfg_rect;
    logic           cfg_commit;
    logic           hit_valid;
    logic           hit;
    logic [IDW-1:0] hit_id;
    logic [N-1:0]   hit_mask;
    logic           collide;

    int checks   = 0;
    int failures = 0;

    rect_layer_compositor #(.N_RECT(N)) dut (
        .clk         (clk),
        .nRst        (nRst),
        .pix_valid   (pix_valid),
        .x           (x),
        .y           (y),
        .frame_start (frame_start),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_idx     (cfg_idx),
        .cfg_rect    (cfg_rect),
        .cfg_commit  (cfg_commit),
        .hit_valid   (hit_valid),
        .hit         (hit),
        .hit_id      (hit_id),
        .hit_mask    (hit_mask),
        .collide     (collide)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rect_t mk(input logic en, input int x0, input int x1, input int y0, input int y1);
        rect_t r;
        r.en = en;
        r.x0 = 9'(x0);
        r.x1 = 9'(x1);
        r.y0 = 8'(y0);
        r.y1 = 8'(y1);
        return r;
    endfunction

    task automatic wr(input int idx, input rect_t r);
        cfg_valid = 1'b1;
        cfg_idx   = IDW'(idx);
        cfg_rect  = r;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // Drive one pixel, check outputs two edges later, then one idle cycle
    task automatic pix(input string tag, input int px, input int py,
                       input logic eh, input int eid, input int emask);
        pix_valid = 1'b1;
        x = 9'(px);
        y = 8'(py);
        step();
        pix_valid = 1'b0;
        chk({tag, "_s1_vld_low"}, 32'(hit_valid), 32'(0));
        step();
        chk({tag, "_vld"},  32'(hit_valid), 32'(1));
        chk({tag, "_hit"},  32'(hit),       32'(eh));
        chk({tag, "_id"},   32'(hit_id),    32'(eid));
        chk({tag, "_mask"}, 32'(hit_mask),  32'(emask));
        step();
        chk({tag, "_vld_drop"}, 32'(hit_valid), 32'(0));
    endtask

    initial begin
        nRst = 1'b0; pix_valid = 1'b0; x = '0; y = '0; frame_start = 1'b0;
        cfg_valid = 1'b0; cfg_idx = '0; cfg_rect = RECT_NONE; cfg_commit = 1'b0;
        step(); step();
        chk("rst_vld",     32'(hit_valid), 32'(0));
        chk("rst_hit",     32'(hit),       32'(0));
        chk("rst_id",      32'(hit_id),    32'(0));
        chk("rst_mask",    32'(hit_mask),  32'(0));
        chk("rst_collide", 32'(collide),   32'(0));
        chk("rst_ready",   32'(cfg_ready), 32'(1));
        nRst = 1'b1;
        step();

        // Basic single slot
        wr(0, mk(1, 10, 20, 5, 8));
        commit();
        chk("t1_ready_blocked", 32'(cfg_ready), 32'(0));
        frame();
        chk("t1_ready_back", 32'(cfg_ready), 32'(1));
        pix("t1_in",      10, 5, 1, 0, 'h01);
        pix("t1_right",   21, 5, 0, 0, 'h00);
        pix("t1_corner",  20, 8, 1, 0, 'h01);
        pix("t1_below",   10, 9, 0, 0, 'h00);

        // Overlapping slots 2 and 5
        wr(2, mk(1, 40, 60, 40, 60));
        wr(5, mk(1, 50, 70, 50, 70));
        commit();
        frame();
        pix("t2_overlap", 50, 50, 1, 2, 'h24);
        pix("t2_only5",   65, 65, 1, 5, 'h20);
`ifdef RECT_COLLIDE_EN
        frame();
        chk("t2_collide_set", 32'(collide), 32'(1));
        frame();
        chk("t2_collide_clear", 32'(collide), 32'(0));
`else
        frame();
        chk("t2_collide_tied", 32'(collide), 32'(0));
`endif

        // Uncommitted write stays invisible
        wr(1, mk(1, 100, 110, 100, 110));
        frame();
        pix("t3_nocommit_a", 105, 105, 0, 0, 'h00);
        frame();
        pix("t3_nocommit_b", 105, 105, 0, 0, 'h00);
        commit();
        frame();
        pix("t3_committed", 105, 105, 1, 1, 'h02);

        // Write + commit in one cycle; stalled write; commit coincident with frame_start
        cfg_valid = 1'b1; cfg_idx = 3'd3; cfg_rect = mk(1, 200, 210, 0, 10); cfg_commit = 1'b1;
        step();
        cfg_valid = 1'b0; cfg_commit = 1'b0;
        chk("t4_ready_low", 32'(cfg_ready), 32'(0));
        cfg_valid = 1'b1; cfg_idx = 3'd4; cfg_rect = mk(1, 300, 310, 0, 10);
        step();
        cfg_valid = 1'b0;
        frame();
        pix("t4_wr_commit_kept", 205, 5, 1, 3, 'h08);
        pix("t4_stalled_drop",   305, 5, 0, 0, 'h00);
        wr(4, mk(1, 300, 310, 0, 10));
        cfg_commit = 1'b1; frame_start = 1'b1;
        step();
        cfg_commit = 1'b0; frame_start = 1'b0;
        chk("t4_coincident_pending", 32'(cfg_ready), 32'(0));
        pix("t4_not_yet", 305, 5, 0, 0, 'h00);
        frame();
        chk("t4_ready_after", 32'(cfg_ready), 32'(1));
        pix("t4_applied", 305, 5, 1, 4, 'h10);

        // Inverted range and out-of-range index
        wr(4, mk(1, 30, 20, 0, 10));
        chk("t5_ready_before_oor", 32'(cfg_ready), 32'(1));
        wr(6, mk(1, 0, 511, 0, 255));
        chk("t5_ready_after_oor", 32'(cfg_ready), 32'(1));
        commit();
        frame();
        pix("t5_inverted", 25, 5, 0, 0, 'h00);
        pix("t5_old4_gone", 305, 5, 0, 0, 'h00);
        pix("t5_slot0", 10, 5, 1, 0, 'h01);

        // Reset mid-stream with pipeline full and commit pending
        wr(0, mk(1, 0, 511, 0, 255));
        commit();
        pix_valid = 1'b1; x = 9'd10; y = 8'd5; frame_start = 1'b0;
        step(); step();
        chk("t6_pipe_full", 32'(hit_valid), 32'(1));
        nRst = 1'b0;
        step();
        chk("t6_rst_vld",   32'(hit_valid), 32'(0));
        chk("t6_rst_hit",   32'(hit),       32'(0));
        chk("t6_rst_id",    32'(hit_id),    32'(0));
        chk("t6_rst_mask",  32'(hit_mask),  32'(0));
        chk("t6_rst_coll",  32'(collide),   32'(0));
        chk("t6_rst_ready", 32'(cfg_ready), 32'(1));
        nRst = 1'b1; pix_valid = 1'b0;
        step();
        frame();
        chk("t6_no_commit_ready", 32'(cfg_ready), 32'(1));
        pix("t6_empty_a", 10, 5, 0, 0, 'h00);
        pix("t6_empty_b", 300, 200, 0, 0, 'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
